rah_sha_arbiter: RTL and testbench

Shares one SHA-256 core among `NUM_REQ` requester channels, each presenting complete 512-bit message blocks. Grants requesters round-robin, loads the winner's block into the core, and sequences the `sha_en`/`input_valid` start pulse. Captures the 256-bit digest and returns it to the granted requester with a channel ID, and flags a watchdog timeout if the core never answers. Sits between the per-channel Rah bridges and the single SHA core instance.

---
 rtl/rah_sha_pkg.sv | 14 +
 rtl/rah_rr_arbiter.sv | 36 +++
 rtl/rah_sha_arbiter.sv | 136 +++++++++++++
 tb/tb_rah_sha_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rah_sha_pkg.sv
// Shared types and default widths for the Rah SHA-256 arbiter and bridge.
package rah_sha_pkg;

    localparam int DATA_W = 512;
    localparam int HASH_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rah_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rah_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    import rah_sha_pkg::*;

    logic [2*NUM_REQ-1:0] rotated;
    logic [ID_W:0]        pick;

    always_comb begin
        // Bit 0 of the rotated vector is req[ptr], so the lowest set bit is the winner.
        rotated = {req, req} >> ptr;
        pick    = '0;
        any     = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pick = {1'b0, ptr} + (ID_W + 1)'(i);
                any  = 1'b1;
            end
        end
        if (pick >= (ID_W + 1)'(NUM_REQ)) begin
            pick = pick - (ID_W + 1)'(NUM_REQ);
        end
        gnt_id = pick[ID_W-1:0];
        gnt    = any ? (NUM_REQ'(1) << pick) : '0;
    end

endmodule

// File: rtl/rah_sha_arbiter.sv
// Shares one SHA-256 core among NUM_REQ block requesters: round-robin grant,
// start pulse, digest capture with watchdog, and response hand-back.
module rah_sha_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = rah_sha_pkg::DATA_W,
    parameter int HASH_W         = rah_sha_pkg::HASH_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         sha_input_data,
    output logic                      input_valid,
    output logic                      sha_en,
    input  logic                      output_valid,
    input  logic [HASH_W-1:0]         hash1_out,
    input  logic                      sha_done,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [HASH_W-1:0]         rsp_hash,
    output logic                      rsp_error,
    output logic                      busy
);

    import rah_sha_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_id;
    logic [WD_W-1:0]     wdog;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_id;
    logic                arb_any;
    logic [DATA_W-1:0]   sel_data;
    logic                wd_expire;
    logic [ID_W-1:0]     next_ptr;
    logic                sha_done_unused;

    assign sha_done_unused = sha_done;

    rah_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The counter would reach TIMEOUT_CYCLES-1 on this edge, which lands the
    // error response exactly TIMEOUT_CYCLES cycles after the start pulse edge.
    assign wd_expire = (wdog == WD_W'(TIMEOUT_CYCLES - 2));
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_id       <= '0;
            wdog           <= '0;
            req_ready      <= '0;
            sha_input_data <= '0;
            input_valid    <= 1'b0;
            sha_en         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_hash       <= '0;
            rsp_error      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            req_ready   <= '0;
            sha_en      <= 1'b0;
            input_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        sha_input_data <= sel_data;
                        grant_id       <= arb_id;
                        req_ready      <= arb_gnt;
                        sha_en         <= 1'b1;
                        input_valid    <= 1'b1;
                        busy           <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (output_valid) begin
                        rsp_hash  <= hash1_out;
                        rsp_error <= 1'b0;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd_expire) begin
                        rsp_hash  <= '0;
                        rsp_error <= 1'b1;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rah_sha_arbiter.sv
// Directed bench for rah_sha_arbiter: one task per scenario with inline checks.
module tb_rah_sha_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 512;
    localparam int HASH_W   = 256;
    localparam int TIMEOUT  = 16;
    localparam int ID_W     = 2;
    localparam int CORE_LAT = 12;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         sha_input_data;
    logic                      input_valid;
    logic                      sha_en;
    logic                      output_valid = 1'b0;
    logic [HASH_W-1:0]         hash1_out = '0;
    logic                      sha_done = 1'b0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [ID_W-1:0]           rsp_id;
    logic [HASH_W-1:0]         rsp_hash;
    logic                      rsp_error;
    logic                      busy;

    int vectors     = 0;
    int miscompares = 0;
    int sha_en_cnt  = 0;
    int ready_cnt   = 0;

    logic [DATA_W-1:0] abc_blk  = {32'h61626380, 416'h0, 64'h18};
    logic [HASH_W-1:0] abc_hash = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    always #5 clk = ~clk;

    rah_sha_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .HASH_W         (HASH_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ID_W           (ID_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .sha_input_data (sha_input_data),
        .input_valid    (input_valid),
        .sha_en         (sha_en),
        .output_valid   (output_valid),
        .hash1_out      (hash1_out),
        .sha_done       (sha_done),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_hash       (rsp_hash),
        .rsp_error      (rsp_error),
        .busy           (busy)
    );

    always @(negedge clk) begin
        if (sha_en === 1'b1) sha_en_cnt++;
        if (req_ready !== '0) ready_cnt++;
    end

    function automatic logic [DATA_W-1:0] mk_data(input int ch);
        return {8'(ch + 1), 496'h0, 8'(ch + 16)};
    endfunction

    function automatic logic [HASH_W-1:0] mk_hash(input int ch);
        return {8'(ch + 32), 240'h0, 8'(ch + 48)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int id);
        int n = 0;
        id = -1;
        while (sha_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (sha_en !== 1'b1) begin
            $display("FAIL grant_wait: sha_en=%b after %0d cycles, required 1", sha_en, n);
            miscompares++;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) id = i;
        end
    endtask

    task automatic core_reply(input logic [HASH_W-1:0] h);
        output_valid = 1'b1;
        sha_done     = 1'b1;
        hash1_out    = h;
        step();
        output_valid = 1'b0;
        sha_done     = 1'b0;
        hash1_out    = '0;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rsp_release: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({req_ready, input_valid, sha_en, rsp_valid, rsp_id, rsp_error, busy} !== '0 ||
            sha_input_data !== '0 || rsp_hash !== '0) begin
            $display("FAIL reset_outputs: ready=%b iv=%b en=%b rv=%b id=%0d err=%b busy=%b",
                     req_ready, input_valid, sha_en, rsp_valid, rsp_id, rsp_error, busy);
            miscompares++;
        end
        rst_n = 1'b1;
        repeat (2) step();
        vectors++;
        if (busy !== 1'b0 || sha_en !== 1'b0) begin
            $display("FAIL reset_idle: busy=%b sha_en=%b, required 0 0", busy, sha_en);
            miscompares++;
        end
    endtask

    task automatic test_single();
        int id;
        int en0 = sha_en_cnt;
        int rd0 = ready_cnt;
        req_data[2*DATA_W +: DATA_W] = abc_blk;
        req_valid = 4'b0100;
        wait_grant(id);
        req_valid = '0;
        if (id < 0) return;
        vectors++;
        if (req_ready !== 4'b0100 || input_valid !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL single_grant: ready=%b iv=%b busy=%b, required 0100 1 1", req_ready, input_valid, busy);
            miscompares++;
        end
        vectors++;
        if (sha_input_data !== abc_blk) begin
            $display("FAIL single_data: got %h, required %h", sha_input_data, abc_blk);
            miscompares++;
        end
        step();
        vectors++;
        if (sha_en !== 1'b0 || input_valid !== 1'b0 || req_ready !== '0) begin
            $display("FAIL single_pulse_width: en=%b iv=%b ready=%b, required 0 0 0000", sha_en, input_valid, req_ready);
            miscompares++;
        end
        repeat (CORE_LAT - 2) step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL single_early_rsp: rsp_valid=%b, required 0", rsp_valid);
            miscompares++;
        end
        core_reply(abc_hash);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_hash !== abc_hash || rsp_error !== 1'b0) begin
            $display("FAIL single_rsp: rv=%b id=%0d err=%b hash=%h, required 1 2 0 %h",
                     rsp_valid, rsp_id, rsp_error, rsp_hash, abc_hash);
            miscompares++;
        end
        accept_rsp();
        vectors++;
        if (sha_en_cnt - en0 != 1 || ready_cnt - rd0 != 1) begin
            $display("FAIL single_counts: sha_en pulses=%0d ready strobes=%0d, required 1 1",
                     sha_en_cnt - en0, ready_cnt - rd0);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        int id;
        int en0;
        int rd0;
        int bad = 0;
        req_data[1*DATA_W +: DATA_W] = mk_data(1);
        req_valid = 4'b0010;
        wait_grant(id);
        req_valid = '0;
        if (id < 0) return;
        vectors++;
        if (id != 1) begin
            $display("FAIL bp_grant_id: got %0d, required 1", id);
            miscompares++;
        end
        step();
        core_reply(mk_hash(1));
        req_data[3*DATA_W +: DATA_W] = mk_data(3);
        req_valid = 4'b1000;
        en0 = sha_en_cnt;
        rd0 = ready_cnt;
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_hash !== mk_hash(1) || rsp_id !== 2'd1 ||
                sha_en !== 1'b0 || req_ready !== '0) begin
                $display("FAIL bp_hold[%0d]: rv=%b id=%0d en=%b ready=%b hash=%h", k,
                         rsp_valid, rsp_id, sha_en, req_ready, rsp_hash);
                miscompares++;
                bad++;
            end
            step();
        end
        req_valid = '0;
        vectors++;
        if (sha_en_cnt != en0 || ready_cnt != rd0) begin
            $display("FAIL bp_no_issue: sha_en pulses=%0d ready strobes=%0d, required 0 0",
                     sha_en_cnt - en0, ready_cnt - rd0);
            miscompares++;
        end
        accept_rsp();
    endtask

    task automatic test_timeout();
        int id;
        int early = 0;
        req_data[3*DATA_W +: DATA_W] = mk_data(3);
        req_valid = 4'b1000;
        wait_grant(id);
        req_valid = '0;
        if (id < 0) return;
        vectors++;
        if (id != 3) begin
            $display("FAIL to_grant_id: got %0d, required 3", id);
            miscompares++;
        end
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            if (rsp_valid !== 1'b0) early++;
        end
        vectors++;
        if (early != 0) begin
            $display("FAIL to_early: rsp_valid high %0d cycles before expiry, required 0", early);
            miscompares++;
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_hash !== '0 || rsp_id !== 2'd3) begin
            $display("FAIL to_rsp: rv=%b err=%b id=%0d hash=%h, required 1 1 3 0",
                     rsp_valid, rsp_error, rsp_id, rsp_hash);
            miscompares++;
        end
        core_reply(mk_hash(3));
        vectors++;
        if (rsp_hash !== '0 || rsp_error !== 1'b1 || rsp_valid !== 1'b1) begin
            $display("FAIL to_late_in_resp: rv=%b err=%b hash=%h, required 1 1 0", rsp_valid, rsp_error, rsp_hash);
            miscompares++;
        end
        accept_rsp();
        core_reply(mk_hash(2));
        step();
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || sha_en !== 1'b0) begin
            $display("FAIL to_late_in_idle: busy=%b rv=%b en=%b, required 0 0 0", busy, rsp_valid, sha_en);
            miscompares++;
        end
    endtask

    task automatic test_collision();
        int id;
        req_data[0 +: DATA_W] = mk_data(0);
        req_valid = 4'b0001;
        wait_grant(id);
        req_valid = '0;
        if (id < 0) return;
        vectors++;
        if (id != 0) begin
            $display("FAIL col_grant_id: got %0d, required 0", id);
            miscompares++;
        end
        repeat (TIMEOUT - 1) step();
        core_reply(mk_hash(0));
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_hash !== mk_hash(0) || rsp_id !== 2'd0) begin
            $display("FAIL col_rsp: rv=%b err=%b id=%0d hash=%h, required 1 0 0 %h",
                     rsp_valid, rsp_error, rsp_id, rsp_hash, mk_hash(0));
            miscompares++;
        end
        accept_rsp();
    endtask

    task automatic test_reset_mid_wait();
        int id;
        int activity = 0;
        req_data[3*DATA_W +: DATA_W] = mk_data(3);
        req_valid = 4'b1000;
        wait_grant(id);
        req_valid = '0;
        if (id < 0) return;
        vectors++;
        if (id != 3) begin
            $display("FAIL rst_grant_id: got %0d, required 3", id);
            miscompares++;
        end
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, input_valid, sha_en, rsp_valid, rsp_id, rsp_error, busy} !== '0 ||
            sha_input_data !== '0 || rsp_hash !== '0) begin
            $display("FAIL rst_async_outputs: busy=%b rv=%b id=%0d data=%h hash=%h",
                     busy, rsp_valid, rsp_id, sha_input_data, rsp_hash);
            miscompares++;
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) activity++;
        end
        vectors++;
        if (activity != 0) begin
            $display("FAIL rst_no_rsp: %0d active cycles after reset, required 0", activity);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        int id;
        int en0 = sha_en_cnt;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = mk_data(i);
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(id);
            if (id < 0) begin
                req_valid = '0;
                return;
            end
            vectors++;
            if (id != t % NUM_REQ || sha_input_data !== mk_data(t % NUM_REQ)) begin
                $display("FAIL rr_order[%0d]: grant=%0d data=%h, required %0d", t, id, sha_input_data, t % NUM_REQ);
                miscompares++;
            end
            step();
            core_reply(mk_hash(id));
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(id) || rsp_hash !== mk_hash(id)) begin
                $display("FAIL rr_rsp[%0d]: rv=%b id=%0d hash=%h, required 1 %0d", t, rsp_valid, rsp_id, rsp_hash, id);
                miscompares++;
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            if (t == 4) req_valid = '0;
        end
        repeat (3) step();
        vectors++;
        if (sha_en_cnt - en0 != 5) begin
            $display("FAIL rr_pulses: sha_en pulses=%0d, required 5", sha_en_cnt - en0);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        test_round_robin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
